// File: rtl/fila_pedidos.sv
// fila_pedidos: order FIFO and dispatcher feeding the coffee-machine FSM
// Ports: clk/rst (async active-high); order_valid/order_id/order_ready push side;
// machine_state observed FSM state; start request to FSM; busy/busy_id active order;
// done/done_id completion pulse; pending queued orders; fault sticky error.
module fila_pedidos #(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     order_valid,
  input  logic [ID_W-1:0]          order_id,
  output logic                     order_ready,
  input  logic [3:0]               machine_state,
  output logic                     start,
  output logic                     busy,
  output logic [ID_W-1:0]          busy_id,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] D_IDLE  = 2'd0;
  localparam logic [1:0] D_START = 2'd1;
  localparam logic [1:0] D_RUN   = 2'd2;
  localparam logic [1:0] D_FAULT = 2'd3;
  logic [ID_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_cnt;
  logic [1:0]      r_st;
  logic [3:0]      r_prev;
  logic [SW-1:0]   r_stall;
  logic            r_start, r_busy, r_done, r_fault;
  logic [ID_W-1:0] r_busy_id, r_done_id;
  logic w_push, w_pop, w_active, w_same, w_illegal, w_early, w_fin, w_fault;
  assign order_ready = (r_cnt != (AW+1)'(DEPTH)) && !r_fault;
  assign w_push      = order_valid && order_ready;
  assign w_pop       = (r_st == D_IDLE) && (r_cnt != '0) && (machine_state == 4'd1);
  assign w_active    = (r_st == D_START) || (r_st == D_RUN);
  assign w_same      = machine_state == r_prev;
  assign w_illegal   = (machine_state == 4'd0) || (machine_state > 4'd9);
  // only 9 -> 1 is a legitimate return to IDLE once the brew is running
  assign w_early     = (r_st == D_RUN) && (machine_state == 4'd1) && (r_prev != 4'd9);
  assign w_fin       = (r_st == D_RUN) && (machine_state == 4'd1) && (r_prev == 4'd9);
  // r_stall counts edges the state was seen unchanged; this edge would make it TIMEOUT
  assign w_fault     = w_active && (w_illegal || w_early || (w_same && r_stall == SW'(TIMEOUT - 1)));
  assign start   = r_start;
  assign busy    = r_busy;
  assign busy_id = r_busy_id;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign pending = r_cnt;
  assign fault   = r_fault;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= order_id;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_st      <= D_IDLE;
      r_prev    <= '0;
      r_stall   <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_busy_id <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_cnt   <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_prev  <= machine_state;
      r_stall <= (w_active && w_same) ? r_stall + SW'(1) : '0;
      r_done  <= 1'b0;
      if (w_fault) begin
        r_st    <= D_FAULT;
        r_fault <= 1'b1;
        r_start <= 1'b0;
      end else if (w_pop) begin
        r_st      <= D_START;
        r_start   <= 1'b1;
        r_busy    <= 1'b1;
        r_busy_id <= r_mem[r_rd];
      end else if (r_st == D_START && machine_state == 4'd2) begin
        r_st    <= D_RUN;
        r_start <= 1'b0;
      end else if (w_fin) begin
        r_st      <= D_IDLE;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_done_id <= r_busy_id;
      end
    end
  end
endmodule

// File: tb/tb_fila_pedidos.sv
// tb_fila_pedidos: randomized and directed check of fila_pedidos against a queue-based model
module tb_fila_pedidos;
  localparam int DEPTH = 4, ID_W = 4, TIMEOUT = 64;
  logic clk = 0, rst = 1, order_valid = 0;
  logic [ID_W-1:0] order_id = '0;
  logic [3:0] machine_state = 4'd1;
  logic order_ready, start, busy, done, fault;
  logic [ID_W-1:0] busy_id, done_id;
  logic [$clog2(DEPTH):0] pending;
  int n_chk = 0, n_pass = 0;
  int q[$];
  int mode, m_busy, m_busy_id, m_done, m_done_id, m_fault, m_start, prev_ms, same_run;
  int m_seq[$];
  int m_dwell = 0;
  bit auto_m = 0;
  int exp_ids[$];
  fila_pedidos #(.DEPTH(DEPTH), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .order_valid(order_valid), .order_id(order_id),
    .order_ready(order_ready), .machine_state(machine_state), .start(start),
    .busy(busy), .busy_id(busy_id), .done(done), .done_id(done_id),
    .pending(pending), .fault(fault));
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic model_reset();
    q.delete();
    mode = 0; m_busy = 0; m_busy_id = 0; m_done = 0; m_done_id = 0;
    m_fault = 0; m_start = 0; prev_ms = 0; same_run = 0;
  endtask
  // mode: 0 waiting for an order, 1 start raised, 2 brewing, 3 faulted
  task automatic model_step();
    int ms;
    bit act, rdy;
    ms = int'(machine_state);
    act = (mode == 1) || (mode == 2);
    rdy = (q.size() < DEPTH) && (m_fault == 0);
    same_run = (act && ms == prev_ms) ? same_run + 1 : 0;
    m_done = 0;
    if (act && (ms == 0 || ms > 9 || same_run >= TIMEOUT || (mode == 2 && ms == 1 && prev_ms != 9))) begin
      mode = 3; m_fault = 1; m_start = 0;
    end else if (mode == 0 && q.size() > 0 && ms == 1) begin
      m_busy_id = q.pop_front(); m_busy = 1; m_start = 1; mode = 1;
    end else if (mode == 1 && ms == 2) begin
      m_start = 0; mode = 2;
    end else if (mode == 2 && prev_ms == 9 && ms == 1) begin
      m_done = 1; m_done_id = m_busy_id; m_busy = 0; mode = 0;
    end
    if (order_valid && rdy) q.push_back(int'(order_id));
    prev_ms = ms;
  endtask
  task automatic compare();
    chk("pending", int'(pending), q.size());
    chk("order_ready", int'(order_ready), int'(q.size() < DEPTH && m_fault == 0));
    chk("start", int'(start), m_start);
    chk("busy", int'(busy), m_busy);
    chk("busy_id", int'(busy_id), m_busy_id);
    chk("done", int'(done), m_done);
    if (m_done != 0) chk("done_id", int'(done_id), m_done_id);
    chk("fault", int'(fault), m_fault);
  endtask
  // well-behaved coffee machine: answers start and walks the brew sequence
  task automatic m_step();
    if (m_dwell > 0) m_dwell--;
    else if (m_seq.size() > 0) begin
      machine_state = 4'(m_seq.pop_front());
      m_dwell = int'($urandom_range(0, 3));
    end else if (machine_state == 4'd1 && start) begin
      m_seq.push_back(2); m_seq.push_back(3);
      if ($urandom_range(0, 1) == 1) begin m_seq.push_back(4); m_seq.push_back(3); end
      for (int s = 5; s <= 9; s++) m_seq.push_back(s);
      m_seq.push_back(1);
      m_dwell = int'($urandom_range(0, 2));
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (!rst) compare();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #2;
    if (auto_m) m_step();
  endtask
  task automatic push(input int id);
    order_valid = 1; order_id = ID_W'(id);
    tick();
    order_valid = 0;
  endtask
  task automatic go_auto();
    m_seq.delete(); m_dwell = 0; auto_m = 1;
  endtask
  task automatic do_reset();
    rst = 1; auto_m = 0; m_seq.delete(); machine_state = 4'd1; order_valid = 0;
    model_reset();
    tick(); tick();
    rst = 0;
  endtask
  task automatic wait_dones();
    int k;
    k = 0;
    for (int c = 0; c < 3000 && k < exp_ids.size(); c++) begin
      tick();
      if (done) begin chk("done_order", int'(done_id), exp_ids[k]); k++; end
    end
    chk("done_count", k, exp_ids.size());
  endtask
  initial begin
    int s[$];
    bit idle_ok;
    model_reset();
    do_reset();
    chk("rst_pending", int'(pending), 0);
    chk("rst_ready", int'(order_ready), 1);
    chk("rst_busy", int'(busy), 0);
    // single order walking the full brew including a water refill
    push(5);
    chk("single_pending", int'(pending), 1);
    chk("single_start_early", int'(start), 0);
    tick();
    chk("single_start", int'(start), 1);
    chk("single_busy_id", int'(busy_id), 5);
    chk("single_pending0", int'(pending), 0);
    machine_state = 4'd2; tick();
    chk("single_start_drop", int'(start), 0);
    s = '{3, 4, 3, 5, 6, 7, 8, 9};
    foreach (s[i]) begin machine_state = 4'(s[i]); tick(); end
    chk("single_no_early_done", int'(done), 0);
    machine_state = 4'd1; tick();
    chk("single_done", int'(done), 1);
    chk("single_done_id", int'(done_id), 5);
    chk("single_busy0", int'(busy), 0);
    tick();
    chk("single_done_pulse", int'(done), 0);
    // burst fill while the machine is busy at state 7
    push(10); tick();
    s = '{2, 3, 4, 3, 5, 6, 7};
    foreach (s[i]) begin machine_state = 4'(s[i]); tick(); end
    for (int i = 1; i <= 5; i++) push(i);
    chk("burst_pending", int'(pending), 4);
    chk("burst_ready", int'(order_ready), 0);
    go_auto(); m_seq = '{8, 9, 1};
    exp_ids = '{10, 1, 2, 3, 4};
    wait_dones();
    // push and pop on the same edge
    auto_m = 0; machine_state = 4'd3;
    push(7); push(8);
    chk("sim_pending_before", int'(pending), 2);
    machine_state = 4'd1; order_valid = 1; order_id = 4'd9; tick(); order_valid = 0;
    chk("sim_pending", int'(pending), 2);
    chk("sim_busy_id", int'(busy_id), 7);
    chk("sim_start", int'(start), 1);
    go_auto();
    exp_ids = '{7, 8, 9};
    wait_dones();
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      order_valid = ($urandom_range(0, 9) < 4);
      order_id = ID_W'($urandom);
      tick();
    end
    order_valid = 0;
    idle_ok = 0;
    for (int c = 0; c < 1500 && !idle_ok; c++) begin
      tick();
      idle_ok = (pending == 0) && !busy;
    end
    chk("drain", int'(idle_ok), 1);
    // idle dispatcher ignores illegal machine states
    auto_m = 0; machine_state = 4'd0; tick(); machine_state = 4'd15; tick(); tick();
    chk("idle_illegal_ignored", int'(fault), 0);
    // stall
    do_reset();
    push(1); push(2); push(3);
    machine_state = 4'd2; tick();
    machine_state = 4'd5; tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("stall_not_yet", int'(fault), 0);
    tick();
    chk("stall_fault", int'(fault), 1);
    chk("stall_start", int'(start), 0);
    chk("stall_ready", int'(order_ready), 0);
    chk("stall_pending", int'(pending), 2);
    chk("stall_busy", int'(busy), 1);
    push(11); machine_state = 4'd1; tick(); tick();
    chk("stall_sticky", int'(fault), 1);
    // early return 6 -> 1
    do_reset();
    push(4); tick();
    s = '{2, 3, 4, 6, 1};
    foreach (s[i]) begin machine_state = 4'(s[i]); tick(); end
    chk("early_fault", int'(fault), 1);
    chk("early_no_done", int'(done), 0);
    // illegal state while running
    do_reset();
    push(6); tick();
    machine_state = 4'd2; tick();
    machine_state = 4'd12; tick();
    chk("illegal_fault", int'(fault), 1);
    // async reset mid-brew
    do_reset();
    push(1);
    order_valid = 1; order_id = 4'd2; tick();
    order_id = 4'd3; machine_state = 4'd2; tick();
    order_id = 4'd4; machine_state = 4'd3; tick();
    order_valid = 0;
    chk("mid_pending", int'(pending), 3);
    chk("mid_busy", int'(busy), 1);
    #1 rst = 1;
    #1;
    chk("arst_pending", int'(pending), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_busy_id", int'(busy_id), 0);
    chk("arst_start", int'(start), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_fault", int'(fault), 0);
    model_reset();
    tick();
    rst = 0; machine_state = 4'd1;
    push(6); tick();
    chk("arst_redispatch_start", int'(start), 1);
    chk("arst_redispatch_id", int'(busy_id), 6);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fila_pedidos.md
Name: fila_pedidos

Overview:
- Order queue and dispatcher directly upstream of the coffee-machine FSM.
- Buffers coffee order IDs in a FIFO and drives the FSM's start input one order at a time.
- Watches the FSM's 4-bit state output to track acceptance and completion, and reports a completion pulse per order.
- Flags a sticky fault on a stalled or illegal machine state.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ID_W, 4: order ID width.
- TIMEOUT, 64: max cycles the machine state may stay unchanged while an order is active before fault; ≥2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- order_valid  in  1  order request.
- order_id  in  ID_W  ID of offered order.
- order_ready  out  1  FIFO can accept (not full and not fault).
- machine_state  in  4  FSM state: 1 IDLE, 2 LIGAR_MAQUINA, 3 VERIFICAR_AGUA, 4 ENCHER_RESERVATORIO, 5 MOER_CAFE, 6 COLOCAR_NO_FILTRO, 7 PASSAR_AGITADOR, 8 TAMPEAR, 9 REALIZAR_EXTRACAO.
- start  out  1  start request to FSM.
- busy  out  1  an order is dispatched and not yet done.
- busy_id  out  ID_W  ID of active order.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  ID of completed order; valid with done.
- pending  out  clog2(DEPTH)+1  orders in FIFO, excluding the active one.
- fault  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=1): FIFO empty, pending=0, start=0, busy=0, busy_id=0, done=0, done_id=0, fault=0, dispatcher in D_IDLE.
- Push: order_valid && order_ready at clk edge writes order_id at the tail. pending increments the following cycle.
- order_ready = (pending != DEPTH) && !fault. A push while full is ignored, with no overwrite.
- Simultaneous push and pop: both take effect and pending is unchanged. This also works at full, where ready is 0 so no push occurs, and at empty, where no pop occurs.
- Pointers wrap modulo DEPTH.
- Dispatcher FSM:
  - D_IDLE: if pending>0 and machine_state==1, pop the head into busy_id, set busy=1, go to D_START. Pop and start assertion occur on the same edge.
  - D_START: start=1, held while machine_state==1. When machine_state==2 is sampled, start=0 next cycle and go to D_RUN.
  - D_RUN: start=0. Track previous machine_state. On a sampled transition from 9 to 1, the next cycle gives done=1 for exactly one cycle, done_id=busy_id, busy=0, and returns to D_IDLE.
  - The earliest next dispatch is the cycle after done.
  - D_FAULT: start=0, busy holds its last value, no pops. Exit only via rst.
- Dispatch latency: with an empty FIFO and the machine at IDLE, start is high the cycle after the order is pushed.
- Water refill loop (3→4→3→5) is legal in D_RUN and needs no special handling.
- Fault, entered from D_START or D_RUN:
  - Stall: machine_state unchanged for TIMEOUT consecutive cycles. The stall counter resets on any state change and on dispatch.
  - Illegal state: machine_state 0 or >9 sampled.
  - Early return: machine_state returns to 1 from any state other than 9 while in D_RUN.
  - On fault: fault=1 next cycle, sticky; order_ready=0; the FIFO contents are retained.
- D_IDLE ignores machine_state values and does not fault on them. Dispatch simply waits for machine_state==1.
- done and fault never assert in the same cycle; fault has priority and suppresses done.

Test Plan:
- Single order: FSM at 1, push id=5 → start=1 next cycle. FSM moves to 2 → start drops. After FSM walks 2,3,4,3,5..9,1 → done=1 for one cycle with done_id=5, busy=0, pending=0.
- Burst fill: push ids 1,2,3,4,5 back-to-back while the FSM is busy at state 7 → ids 1–4 accepted, order_ready=0 with pending=4, id 5 refused. Completions then occur in order 1,2,3,4.
- Simultaneous push/pop: pending=2, push id=9 on the dispatch cycle → pending stays 2 and busy_id equals the old head.
- Stall: FSM frozen at 5 for 64 cycles after dispatch → fault=1, start=0, order_ready=0, no done. Queued orders remain (pending unchanged).
- Illegal and early return: FSM jumps 6→1 during D_RUN → fault=1. Separately, machine_state=12 in D_RUN → fault=1.
- Async reset mid-brew: rst pulsed while in D_RUN with pending=3 → all outputs zero immediately, without waiting for clk. After release, the next push dispatches normally.
